seg_char_decoder: RTL
=====================

Name: seg_char_decoder

Overview:
- Reverse of the character-to-segment encoder: accepts a 7-bit segment pattern from the team's 32-entry letter font and recovers the 5-bit character code.
- Uses a sequential table search, one entry per clock. Reports match or miss.
- Sits between a segment-pattern source (display readback or scan bus) and the guess-checking logic.

Parameters:
- ACTIVE_LOW_IN, 0, when 1 the incoming pattern is inverted before comparison (active-low segment drivers).
- MISS_CODE, 5'd0, value driven on code_out when no table entry matches.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- seg_in  in  7  segment pattern, bit6..bit0 in font order
- seg_valid  in  1  pattern present on seg_in
- seg_ready  out  1  block can accept a pattern
- code_out  out  5  decoded character code
- code_found  out  1  1 = code_out is a real match, 0 = miss
- code_valid  out  1  one-cycle result strobe
- miss_count  out  8  saturating count of misses since reset

Behaviour:
- Font table (code: pattern bit6..0), fixed, internal:
  - 0:1111110, 1:0001000, 2:1100000, 3:0110001, 4:1000010, 5:0110000, 6:0111000, 7:0000100
  - 8:1101000, 9:1001111, 10:1000111, 11:0101000, 12:1110001, 13:0101011, 14:0001001, 15:0000001
  - 16:0011000, 17:0001100, 18:0111001, 19:0100100, 20:0010101, 21:1000001, 22:1010101, 23:1000000
  - 24:1001000, 25:1000100, 26:0010010, 27:1111001, 28:0010110, 29:0000110, 30:1001100, 31:0110100
  - All entries are unique. The search is ascending, so the first match wins.
- Reset (resetn=0, asynchronous):
  - state=IDLE, idx=0, latched pattern=0
  - code_out=0, code_found=0, code_valid=0, miss_count=0, seg_ready=1
- seg_ready is 1 exactly when state==IDLE (registered-state decode).
- Handshake: a pattern is accepted on the rising edge where seg_valid=1 and seg_ready=1.
  - On acceptance: latch seg_in (inverted if ACTIVE_LOW_IN=1), set idx=0, go to SEARCH.
  - seg_valid while seg_ready=0 is ignored. Nothing is queued.
- SEARCH, each edge:
  - if table[idx]==latched: code_out<=idx, code_found<=1, go to DONE
  - else if idx==31: code_out<=MISS_CODE, code_found<=0, miss_count<=min(miss_count+1,255), go to DONE
  - else idx<=idx+1
- DONE: code_valid=1 for exactly this one cycle, then go to IDLE on the next edge.
- code_valid is decoded from state==DONE, so it is a single-cycle strobe.
- code_out and code_found hold their values until the next result.
- Latency:
  - Accepting edge E0; a match at code k is registered at edge E(k+1).
  - code_valid is high between E(k+1) and E(k+2).
  - Miss: code_valid is high between E32 and E33.
  - seg_ready returns high after E(k+2), so back-to-back throughput is one pattern per k+3 cycles.
- miss_count saturates at 255 with no wrap. Only a reset clears it.
- Reset mid-SEARCH or mid-DONE: immediate return to reset values. A pending result is discarded and no code_valid is produced.
- seg_in is sampled only on the accepting edge. Later changes during SEARCH have no effect.
- X on seg_in while not accepted: no effect.

Test Plan:
- Reset, then seg_in=7'b1111110, seg_valid=1 for one cycle -> code_valid on the cycle after E1, code_out=0, code_found=1, miss_count=0.
- seg_in=7'b0110100 (code 31) -> code_valid after E32, code_out=31, code_found=1. seg_ready is low E0..E33 and high afterwards.
- seg_in=7'b1111111 (not in table), MISS_CODE=0 -> code_valid after E32, code_out=0, code_found=0, miss_count=1. Apply 300 misses -> miss_count=255, held.
- ACTIVE_LOW_IN=1, seg_in=7'b1110111 (inverse of code 1) -> code_out=1, code_found=1 after E2.
- Accept code 20 pattern 7'b0010101. Hold seg_valid=1 with a different pattern 7'b0001000 during SEARCH -> second pattern not accepted until seg_ready=1. Result code_out=20, then code 1 is decoded afterwards.
- Accept code 25, drop resetn at E10 -> all outputs 0 immediately, no code_valid pulse, seg_ready=1 after reset release.

Source files
------------

// File: rtl/seg_char_decoder.sv
// Recovers the 5-bit character code from a 7-segment letter-font pattern by
// walking the 32-entry font table one entry per clock, reporting match or miss.
module seg_char_decoder #(
   parameter bit         ACTIVE_LOW_IN = 1'b0,
   parameter logic [4:0] MISS_CODE     = 5'd0
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [6:0] seg_in,
   input  logic       seg_valid,
   output logic       seg_ready,
   output logic [4:0] code_out,
   output logic       code_found,
   output logic       code_valid,
   output logic [7:0] miss_count
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] DONE   = 2'd2;

   localparam logic [4:0] LAST_IDX = 5'd31;

   // Letter font, bit6..bit0; must stay identical to the encoder's table.
   function automatic logic [6:0] font_pattern(input logic [4:0] code);
      logic [6:0] pat;
      case (code)
         5'd0:    pat = 7'b1111110;
         5'd1:    pat = 7'b0001000;
         5'd2:    pat = 7'b1100000;
         5'd3:    pat = 7'b0110001;
         5'd4:    pat = 7'b1000010;
         5'd5:    pat = 7'b0110000;
         5'd6:    pat = 7'b0111000;
         5'd7:    pat = 7'b0000100;
         5'd8:    pat = 7'b1101000;
         5'd9:    pat = 7'b1001111;
         5'd10:   pat = 7'b1000111;
         5'd11:   pat = 7'b0101000;
         5'd12:   pat = 7'b1110001;
         5'd13:   pat = 7'b0101011;
         5'd14:   pat = 7'b0001001;
         5'd15:   pat = 7'b0000001;
         5'd16:   pat = 7'b0011000;
         5'd17:   pat = 7'b0001100;
         5'd18:   pat = 7'b0111001;
         5'd19:   pat = 7'b0100100;
         5'd20:   pat = 7'b0010101;
         5'd21:   pat = 7'b1000001;
         5'd22:   pat = 7'b1010101;
         5'd23:   pat = 7'b1000000;
         5'd24:   pat = 7'b1001000;
         5'd25:   pat = 7'b1000100;
         5'd26:   pat = 7'b0010010;
         5'd27:   pat = 7'b1111001;
         5'd28:   pat = 7'b0010110;
         5'd29:   pat = 7'b0000110;
         5'd30:   pat = 7'b1001100;
         5'd31:   pat = 7'b0110100;
         // NOTE: a default arm keeps combinational case logic free of latches.
         default: pat = 7'b0000000;
      endcase
      return pat;
   endfunction

   logic [1:0] state;
   logic [4:0] idx;
   logic [6:0] pattern;
   logic       hit;

   assign seg_ready  = (state == IDLE);
   assign code_valid = (state == DONE);
   assign hit        = (font_pattern(idx) == pattern);

   // NOTE: all registered state uses non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         idx        <= 5'd0;
         pattern    <= 7'd0;
         code_out   <= 5'd0;
         code_found <= 1'b0;
         miss_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (seg_valid) begin
                  pattern <= ACTIVE_LOW_IN ? ~seg_in : seg_in;
                  idx     <= 5'd0;
                  state   <= SEARCH;
               end
            end
            SEARCH: begin
               if (hit) begin
                  code_out   <= idx;
                  code_found <= 1'b1;
                  state      <= DONE;
               end else if (idx == LAST_IDX) begin
                  code_out   <= MISS_CODE;
                  code_found <= 1'b0;
                  if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                  state      <= DONE;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
